// File: rtl/mat_compute.sv
// Matrix-multiply compute stage: reads A (M x K) and B (K x N) from a 1-cycle-latency
// memory, accumulates each C[i][j] and streams results row-major on an AXI-Stream master.
module mat_compute #(
  parameter int INW  = 12,
  parameter int OUTW = 28,
  parameter int M    = 7,
  parameter int N    = 9,
  parameter int MAXK = 8,
  localparam int K_BITS      = $clog2(MAXK + 1),
  localparam int A_ADDR_BITS = $clog2(M * MAXK),
  localparam int B_ADDR_BITS = $clog2(MAXK * N)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          matrices_loaded,
  input  logic        [K_BITS-1:0]      K,
  output logic        [A_ADDR_BITS-1:0] A_read_addr,
  input  logic signed [INW-1:0]         A_data,
  output logic        [B_ADDR_BITS-1:0] B_read_addr,
  input  logic signed [INW-1:0]         B_data,
  output logic                          compute_finished,
  output logic signed [OUTW-1:0]        AXIS_TDATA,
  output logic                          AXIS_TVALID,
  input  logic                          AXIS_TREADY
);

  localparam int I_BITS = (M > 1) ? $clog2(M) : 1;
  localparam int J_BITS = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_OUT, S_FINISH} state_t;

  state_t                   state_q, state_d;
  logic [I_BITS-1:0]        i_q, i_d;
  logic [J_BITS-1:0]        j_q, j_d;
  logic [K_BITS-1:0]        k_q, k_d;
  logic [K_BITS-1:0]        kreg_q, kreg_d;
  logic [A_ADDR_BITS-1:0]   a_row_q, a_row_d;
  logic [A_ADDR_BITS-1:0]   a_ptr_q, a_ptr_d;
  logic [B_ADDR_BITS-1:0]   b_ptr_q, b_ptr_d;
  logic                     vld_q, vld_d;
  logic signed [OUTW-1:0]   acc_q, acc_d;
  logic signed [OUTW-1:0]   tdata_q, tdata_d;
  logic                     tvalid_q, tvalid_d;

  logic signed [2*INW-1:0]  prod;
  logic signed [OUTW-1:0]   prod_ext;
  logic signed [OUTW-1:0]   mac_sum;

  assign prod     = A_data * B_data;
  assign prod_ext = {{(OUTW-2*INW){prod[2*INW-1]}}, prod};
  assign mac_sum  = acc_q + prod_ext;

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    kreg_d   = kreg_q;
    a_row_d  = a_row_q;
    a_ptr_d  = a_ptr_q;
    b_ptr_d  = b_ptr_q;
    vld_d    = 1'b0;
    acc_d    = vld_q ? mac_sum : acc_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;

    case (state_q)
      S_IDLE: begin
        if (matrices_loaded) begin
          kreg_d  = K;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          a_row_d = '0;
          a_ptr_d = '0;
          b_ptr_d = '0;
          if (K == '0) begin
            tdata_d  = '0;
            tvalid_d = 1'b1;
            state_d  = S_OUT;
          end else begin
            state_d = S_MAC;
          end
        end
      end
      S_MAC: begin
        // vld_q lines up with the memory's one-cycle read latency
        vld_d = 1'b1;
        if (k_q == kreg_q - K_BITS'(1)) begin
          state_d = S_DRAIN;
        end else begin
          k_d     = k_q + K_BITS'(1);
          a_ptr_d = a_ptr_q + A_ADDR_BITS'(1);
          b_ptr_d = b_ptr_q + B_ADDR_BITS'(N);
        end
      end
      S_DRAIN: begin
        tdata_d  = mac_sum;
        tvalid_d = 1'b1;
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (AXIS_TREADY) begin
          if (i_q == I_BITS'(M - 1) && j_q == J_BITS'(N - 1)) begin
            tvalid_d = 1'b0;
            state_d  = S_FINISH;
          end else begin
            if (j_q == J_BITS'(N - 1)) begin
              j_d     = '0;
              i_d     = i_q + I_BITS'(1);
              a_row_d = a_row_q + A_ADDR_BITS'(kreg_q);
            end else begin
              j_d = j_q + J_BITS'(1);
            end
            a_ptr_d = a_row_d;
            b_ptr_d = B_ADDR_BITS'(j_d);
            k_d     = '0;
            acc_d   = '0;
            // With K=0 every result is zero, so stay in OUT with TVALID held
            if (kreg_q != '0) begin
              tvalid_d = 1'b0;
              state_d  = S_MAC;
            end
          end
        end
      end
      S_FINISH: begin
        a_row_d = '0;
        a_ptr_d = '0;
        b_ptr_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      kreg_q   <= '0;
      a_row_q  <= '0;
      a_ptr_q  <= '0;
      b_ptr_q  <= '0;
      vld_q    <= 1'b0;
      acc_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      kreg_q   <= kreg_d;
      a_row_q  <= a_row_d;
      a_ptr_q  <= a_ptr_d;
      b_ptr_q  <= b_ptr_d;
      vld_q    <= vld_d;
      acc_q    <= acc_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign A_read_addr      = a_ptr_q;
  assign B_read_addr      = b_ptr_q;
  assign AXIS_TDATA       = tdata_q;
  assign AXIS_TVALID      = tvalid_q;
  assign compute_finished = (state_q == S_FINISH);

endmodule

// File: tb/tb_mat_compute.sv
// Bench for mat_compute: memory model, scoreboard queue fed by the stimulus and
// drained by a monitor on every TVALID&TREADY handshake.
module tb_mat_compute;
  localparam int INW  = 12;
  localparam int OUTW = 28;
  localparam int M    = 7;
  localparam int N    = 9;
  localparam int MAXK = 8;
  localparam int KB   = $clog2(MAXK + 1);
  localparam int AB   = $clog2(M * MAXK);
  localparam int BB   = $clog2(MAXK * N);

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   matrices_loaded = 1'b0;
  logic [KB-1:0]          K = '0;
  logic [AB-1:0]          A_read_addr;
  logic signed [INW-1:0]  A_data = '0;
  logic [BB-1:0]          B_read_addr;
  logic signed [INW-1:0]  B_data = '0;
  logic                   compute_finished;
  logic signed [OUTW-1:0] AXIS_TDATA;
  logic                   AXIS_TVALID;
  logic                   AXIS_TREADY = 1'b1;

  mat_compute #(.INW(INW), .OUTW(OUTW), .M(M), .N(N), .MAXK(MAXK)) dut (
    .clk(clk), .reset(reset), .matrices_loaded(matrices_loaded), .K(K),
    .A_read_addr(A_read_addr), .A_data(A_data),
    .B_read_addr(B_read_addr), .B_data(B_data),
    .compute_finished(compute_finished),
    .AXIS_TDATA(AXIS_TDATA), .AXIS_TVALID(AXIS_TVALID), .AXIS_TREADY(AXIS_TREADY)
  );

  always #5 clk = ~clk;

  logic signed [INW-1:0] amem [64];
  logic signed [INW-1:0] bmem [128];

  always @(posedge clk) begin
    A_data <= amem[A_read_addr];
    B_data <= bmem[B_read_addr];
  end

  int checks = 0;
  int errors = 0;
  logic signed [OUTW-1:0] exp_q[$];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor / scoreboard
  int   cyc = 0;
  int   hs_total = 0;
  int   last_hs_cyc = -10;
  int   fin_count = 0;
  int   batch_base = 0;
  int   kcur = 0;
  logic range_en = 1'b0;
  logic stall_pend = 1'b0;
  logic signed [OUTW-1:0] stall_data = '0;
  logic signed [OUTW-1:0] e;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (stall_pend) begin
        check("stall_tvalid_held", AXIS_TVALID, 1);
        check("stall_tdata_held", AXIS_TDATA, stall_data);
      end
      stall_pend = AXIS_TVALID && !AXIS_TREADY;
      stall_data = AXIS_TDATA;
      if (AXIS_TVALID && AXIS_TREADY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_output: got data %0d, required no output", AXIS_TDATA);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("tdata[%0d]", hs_total - batch_base), AXIS_TDATA, e);
        end
        hs_total++;
        last_hs_cyc = cyc;
      end
      if (compute_finished) begin
        fin_count++;
        check("finish_cycles_after_last_hs", cyc - last_hs_cyc, 1);
        check("finish_outputs_in_batch", hs_total - batch_base, M * N);
      end
      if (range_en && kcur > 0) begin
        check("a_addr_in_range", int'(A_read_addr) < M * kcur, 1);
        check("b_addr_in_range", int'(B_read_addr) < kcur * N, 1);
      end
    end else begin
      stall_pend = 1'b0;
    end
  end

  // TREADY driver: always ready, or random with a forced 10-cycle stall on element (3,4)
  logic stall_mode = 1'b0;
  int   stall_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (!stall_mode) begin
      AXIS_TREADY = 1'b1;
    end else if (hs_total - batch_base == 3 * N + 4 && stall_cnt < 10) begin
      AXIS_TREADY = 1'b0;
      if (AXIS_TVALID) stall_cnt++;
    end else begin
      AXIS_TREADY = 1'($urandom_range(0, 1));
    end
  end

  task automatic fill_const(input int k, input int av, input int bv);
    for (int i = 0; i < M; i++)
      for (int kk = 0; kk < k; kk++) amem[i*k+kk] = INW'(av);
    for (int kk = 0; kk < k; kk++)
      for (int j = 0; j < N; j++) bmem[kk*N+j] = INW'(bv);
  endtask

  task automatic push_const(input int v);
    for (int n = 0; n < M * N; n++) exp_q.push_back(OUTW'(v));
  endtask

  task automatic run_batch(input int k);
    int lat;
    int n;
    int f0;
    f0 = fin_count;
    kcur = k;
    K = KB'(k);
    batch_base = hs_total;
    range_en = 1'b1;
    @(posedge clk);
    #1 matrices_loaded = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1 && k > 0) begin
        check("first_mac_a_addr", A_read_addr, 0);
        check("first_mac_b_addr", B_read_addr, 0);
      end
    end while (!AXIS_TVALID && lat < 200);
    check($sformatf("first_tvalid_latency_k%0d", k), lat, (k == 0) ? 1 : k + 2);
    n = 0;
    while (!compute_finished && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("batch_finished_within_budget", n < 20000, 1);
    @(posedge clk);
    #1 matrices_loaded = 1'b0;
    range_en = 1'b0;
    check("finish_pulse_single_cycle", compute_finished, 0);
    check("finish_pulses_per_batch", fin_count - f0, 1);
    check("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required clean finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int a = 0; a < 64; a++) amem[a] = '0;
    for (int b = 0; b < 128; b++) bmem[b] = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_tvalid", AXIS_TVALID, 0);
    check("reset_tdata", AXIS_TDATA, 0);
    check("reset_finished", compute_finished, 0);
    check("reset_a_addr", A_read_addr, 0);
    check("reset_b_addr", B_read_addr, 0);
    #2 reset = 1'b1;

    // 1: K=3, ones times twos
    fill_const(3, 1, 2);
    push_const(6);
    run_batch(3);

    // 2: extreme negative operands, then mixed sign
    fill_const(8, -2048, -2048);
    push_const(33554432);
    run_batch(8);
    fill_const(8, -2048, 2047);
    push_const(-33538048);
    run_batch(8);

    // 3: K=1, A[i]=i, B[j]=j+1
    for (int i = 0; i < M; i++) amem[i] = INW'(i);
    for (int j = 0; j < N; j++) bmem[j] = INW'(j + 1);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) exp_q.push_back(OUTW'(i * (j + 1)));
    run_batch(1);

    // 4: K=2 under back-pressure, C[i][j] = 2*3*(j-4)
    fill_const(2, 3, 0);
    for (int kk = 0; kk < 2; kk++)
      for (int j = 0; j < N; j++) bmem[kk*N+j] = INW'(j - 4);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) exp_q.push_back(OUTW'(6 * (j - 4)));
    stall_mode = 1'b1;
    run_batch(2);
    stall_mode = 1'b0;
    check("stall_on_element_3_4_applied", stall_cnt, 10);

    // 5: K=0 with non-zero memory contents
    fill_const(8, 5, 7);
    push_const(0);
    run_batch(0);

    // 6: reset while element (2,5) is presented, then a clean restart
    fill_const(3, 1, 2);
    push_const(6);
    kcur = 3;
    K = KB'(3);
    batch_base = hs_total;
    range_en = 1'b1;
    @(posedge clk);
    #1 matrices_loaded = 1'b1;
    n = 0;
    while (!(hs_total - batch_base == 2 * N + 5 && AXIS_TVALID) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reached_element_2_5", hs_total - batch_base, 2 * N + 5);
    #2 reset = 1'b0;
    #1;
    check("reset_mid_tvalid", AXIS_TVALID, 0);
    check("reset_mid_finished", compute_finished, 0);
    check("reset_mid_a_addr", A_read_addr, 0);
    check("reset_mid_tdata", AXIS_TDATA, 0);
    matrices_loaded = 1'b0;
    range_en = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("idle_after_reset_tvalid", AXIS_TVALID, 0);
    end
    push_const(6);
    run_batch(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mat_compute.md
Name: mat_compute

Overview:
- Downstream compute stage of the input memory block: once `matrices_loaded` is high, reads A (M x K) and B (K x N) through the block's read ports and computes C = A·B.
- Streams the M·N results of C out in row-major order on an AXI-Stream master.
- Pulses `compute_finished` so the input memory block can accept the next matrix pair.

Parameters:
- INW, 12, signed element width of A and B.
- OUTW, 28, signed result width (≥ 2·INW + clog2(MAXK)).
- M, 7, rows of A and C.
- N, 9, columns of B and C.
- MAXK, 8, maximum inner dimension.
- K_BITS, clog2(MAXK+1), localparam.
- A_ADDR_BITS, clog2(M·MAXK), localparam.
- B_ADDR_BITS, clog2(MAXK·N), localparam.

Ports:
- clk  input  1  single clock; all state on posedge clk.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- matrices_loaded  input  1  A and B are valid in memory.
- K  input  K_BITS  inner dimension; valid while matrices_loaded=1.
- A_read_addr  output  A_ADDR_BITS  A element address.
- A_data  input  INW signed  A word; 1-cycle registered read latency.
- B_read_addr  output  B_ADDR_BITS  B element address.
- B_data  input  INW signed  B word; 1-cycle latency.
- compute_finished  output  1  one-cycle pulse after the last result is accepted.
- AXIS_TDATA  output  OUTW signed  result C[i][j].
- AXIS_TVALID  output  1  result valid.
- AXIS_TREADY  input  1  downstream ready.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - i, j, k, accumulator and K register cleared.
  - AXIS_TVALID=0, AXIS_TDATA=0, compute_finished=0, A_read_addr=0, B_read_addr=0.
  - Reset mid-operation abandons the batch; no partial output is emitted after release.
- Memory layout is fixed by the writer:
  - A_read_addr = i·Kreg + k (A row-major).
  - B_read_addr = k·N + j (B row-major).
  - Addresses are formed from incrementing base counters, not multipliers.
- States: IDLE, MAC, DRAIN, OUT, FINISH.
- IDLE:
  - If matrices_loaded=1: capture K into Kreg, set i=j=k=0, clear acc.
  - Then go to MAC, or to OUT with acc=0 if K=0.
- MAC:
  - Each cycle presents addresses for (i, j, k).
  - A valid flag delayed one cycle gates `acc += A_data·B_data`.
  - Product is a full 2·INW signed value, sign-extended to OUTW; accumulation wraps modulo 2^OUTW.
  - When the address for k = Kreg−1 is issued, go to DRAIN.
- DRAIN:
  - Accumulates the final product.
  - Drives AXIS_TDATA = final sum and TVALID=1 from the next cycle; go to OUT.
- Timing: TVALID rises exactly Kreg+1 cycles after MAC entry.
- OUT:
  - TVALID=1; TDATA is held stable until TVALID&TREADY.
  - On handshake with (i,j) = (M−1, N−1): TVALID=0, go to FINISH.
  - On any other handshake: j++, or j=0 and i++ when j=N−1; clear acc, k=0; go to MAC (or remain in the K=0 path).
  - With TREADY held high there is no bubble beyond the Kreg+1 compute latency per element.
- FINISH:
  - compute_finished=1 for exactly one cycle; then IDLE.
  - matrices_loaded is sampled again only from IDLE on the following cycle. The upstream block drops it on that same edge, so no re-trigger on the stale batch.
- Kreg is held constant for the whole batch; changes on K mid-batch are ignored.
- No addresses beyond M·Kreg−1 (A) or Kreg·N−1 (B) are ever issued.

Test Plan:
1. K=3, all A=1, all B=2, TREADY=1 → 63 outputs of value 6, row-major. compute_finished pulses once, 1 cycle after the 63rd handshake.
2. K=8, all A=−2048, all B=−2048 → every output = 33554432. All A=−2048 and B=2047 → every output = −33538048 (no sign error).
3. K=1, A[i]=i, B[j]=j+1 → C[i][j]=i·(j+1). TVALID 2 cycles after MAC entry. Addresses A=i, B=j observed.
4. K=2, TREADY low 10 cycles on element (3,4) and randomly toggled elsewhere → TDATA/TVALID stable while stalled; no drop or duplicate; 63 results in order.
5. K=0 → 63 zeros emitted; no memory-dependent accumulation; compute_finished pulses.
6. Assert reset during element (2,5) → TVALID and compute_finished drop immediately. After release the block waits in IDLE for matrices_loaded, then restarts from (0,0) with correct results.
